game_gen_scheduler: RTL

//  Owns the current Game-of-Life field and sequences the cell simulator one generation at a time.

---
 rtl/game_gen_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/game_gen_scheduler.sv
// game_gen_scheduler: owns the Game-of-Life field and sequences the cell simulator.
// User cell edits and generation launches share the field. Launches are paced by a
// programmable tick period while running, or started by a single step while paused.
// Optional feature macro: GAME_SCHED_GEN_COUNT_EN adds a 16-bit generation counter
// output (gen_count) that is cleared by any accepted edit.
module game_gen_scheduler #(
    parameter int unsigned FIELD_W = 40,
    parameter int unsigned FIELD_H = 30,
    parameter int unsigned TICK_W  = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              run_toggle,
    input  logic                              step,
    input  logic [TICK_W-1:0]                 period_cfg,
    input  logic                              edit_vld,
    input  logic [5:0]                        edit_x,
    input  logic [4:0]                        edit_y,
    output logic                              edit_rdy,
    output logic                              sim_go,
    input  logic                              sim_done,
    input  logic [FIELD_H-1:0][FIELD_W-1:0]   sim_field_next,
    output logic [FIELD_H-1:0][FIELD_W-1:0]   field,
    output logic                              running,
    output logic                              busy
`ifdef GAME_SCHED_GEN_COUNT_EN
    ,
    output logic [15:0]                       gen_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_CLR  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   period_m1;
    logic                tick_hit;
    logic                edit_acc;
    logic                edit_in_range;
    logic                launch;
    logic                commit;

    // A period of 0 behaves as 1: launch as soon as the field is idle.
    assign period_m1     = (period_cfg == '0) ? '0 : (period_cfg - TICK_W'(1));
    assign tick_hit      = (tick >= period_m1);
    assign edit_in_range = (32'(edit_x) < FIELD_W) && (32'(edit_y) < FIELD_H);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle decode; edits take priority over launches in IDLE.
    always_comb begin
        state_nxt = state;
        edit_acc  = 1'b0;
        launch    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (edit_vld) begin
                    edit_acc = 1'b1;
                end else if ((running && tick_hit) || (!running && step)) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_CLR;
            end
            WAIT_CLR: begin
                // Done may still be high from the previous generation.
                if (!sim_done) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sim_done) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered handshake/status outputs, decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edit_rdy <= 1'b1;
            sim_go   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            edit_rdy <= (state_nxt == IDLE);
            sim_go   <= (state_nxt == LAUNCH);
            busy     <= (state_nxt != IDLE);
        end
    end

    // Run flag flips on any toggle pulse; an in-flight generation is never aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
        end else if (run_toggle) begin
            running <= ~running;
        end
    end

    // Period counter: counts idle running cycles, saturates, clears on launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (state == LAUNCH) begin
            tick <= '0;
        end else if (running && (state == IDLE) && (tick != '1)) begin
            tick <= tick + TICK_W'(1);
        end
    end

    // Field storage: simulator result commits, user edits toggle one cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field <= '0;
        end else if (commit) begin
            field <= sim_field_next;
        end else if (edit_acc && edit_in_range) begin
            field[edit_y][edit_x] <= ~field[edit_y][edit_x];
        end
    end

`ifdef GAME_SCHED_GEN_COUNT_EN
    // Generations committed since the last user edit; wraps at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_count <= '0;
        end else if (commit) begin
            gen_count <= gen_count + 16'(1);
        end else if (edit_acc) begin
            gen_count <= '0;
        end
    end
`endif

endmodule
